// File: rtl/vcve2_vrf_agu_pkg.sv
// Shared types and constants for the VRF address generation unit.
package vcve2_vrf_agu_pkg;

  typedef enum logic [2:0] {
    LMUL_1    = 3'b000,
    LMUL_2    = 3'b001,
    LMUL_4    = 3'b010,
    LMUL_8    = 3'b011,
    LMUL_RSVD = 3'b100,
    LMUL_F8   = 3'b101,
    LMUL_F4   = 3'b110,
    LMUL_F2   = 3'b111
  } vlmul_e;

  typedef enum logic [1:0] {
    AGU_IDLE  = 2'd0,
    AGU_CALC  = 2'd1,
    AGU_READY = 2'd2
  } agu_state_t;

  localparam int unsigned VLENB       = 16;  // bytes per vector register (VLEN=128)
  localparam int unsigned WORD_BYTES  = 4;   // bytes per memory access (PIPE_WIDTH=32)
  localparam int unsigned NUM_MEM_OPS = 3;

  localparam int unsigned OP_RS1 = 0;
  localparam int unsigned OP_RS2 = 1;
  localparam int unsigned OP_RD  = 2;

  // Words in one register group; fractional groups never shrink below one word.
  // The reserved encoding falls through to the m1 length.
  function automatic int unsigned lmul_words(vlmul_e lmul, int unsigned words_per_reg);
    int unsigned nw;
    case (lmul)
      LMUL_2:  nw = words_per_reg << 1;
      LMUL_4:  nw = words_per_reg << 2;
      LMUL_8:  nw = words_per_reg << 3;
      LMUL_F2: nw = words_per_reg >> 1;
      LMUL_F4: nw = words_per_reg >> 2;
      LMUL_F8: nw = words_per_reg >> 3;
      default: nw = words_per_reg;
    endcase
    if (nw == 0) nw = 1;
    return nw;
  endfunction

  // Number of architectural registers a group occupies: max(1, 2^lmul).
  function automatic int unsigned lmul_span(vlmul_e lmul);
    int unsigned span;
    case (lmul)
      LMUL_2:  span = 2;
      LMUL_4:  span = 4;
      LMUL_8:  span = 8;
      default: span = 1;
    endcase
    return span;
  endfunction

endpackage

// File: rtl/vcve2_vrf_agu_if.sv
// Request/response bundle between the VRF interface FSM (master) and the AGU (slave).
interface vcve2_vrf_agu_if
  import vcve2_vrf_agu_pkg::*;
#(
  parameter int unsigned AddrWidth = 5
);

  logic                 load_i;
  logic [AddrWidth-1:0] vs1_i;
  logic [AddrWidth-1:0] vs2_i;
  logic [AddrWidth-1:0] vd_i;
  vlmul_e               lmul_i;
  logic                 get_rs1_i;
  logic                 get_rs2_i;
  logic                 get_rd_i;
  logic                 data_we_i;
  logic [3:0]           sel_operation_i;
  logic                 ready_o;
  logic [31:0]          data_addr_o;
  logic                 err_o;

  modport master (
    output load_i, vs1_i, vs2_i, vd_i, lmul_i,
    output get_rs1_i, get_rs2_i, get_rd_i, data_we_i, sel_operation_i,
    input  ready_o, data_addr_o, err_o
  );

  modport slave (
    input  load_i, vs1_i, vs2_i, vd_i, lmul_i,
    input  get_rs1_i, get_rs2_i, get_rd_i, data_we_i, sel_operation_i,
    output ready_o, data_addr_o, err_o
  );

endinterface

// File: rtl/vcve2_vrf_agu_ptr.sv
// One operand pointer: register base address plus a word offset that wraps at the group length.
module vcve2_vrf_agu_ptr #(
  parameter int unsigned AddrWidth   = 5,
  parameter int unsigned OffWidth    = 5,
  parameter int unsigned VlenbShift  = 4,
  parameter int unsigned WordShift   = 2,
  parameter logic [31:0] VrfBaseAddr = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 i_load,
  input  logic                 i_calc,
  input  logic                 i_adv,
  input  logic [AddrWidth-1:0] i_idx,
  input  logic [OffWidth:0]    i_nw,
  output logic [31:0]          o_addr
);

  localparam logic [OffWidth:0]   NwOne  = 1;
  localparam logic [OffWidth-1:0] OffOne = 1;

  logic [31:0]         r_base;
  logic [OffWidth-1:0] r_off;
  logic [OffWidth:0]   w_last;
  logic                w_at_last;

  assign w_last    = i_nw - NwOne;
  // >= rather than == keeps the counter bounded even if the group length shrinks underneath it
  assign w_at_last = ({1'b0, r_off} >= w_last);

  // Base address: register index scaled by the register size, wraps mod 2^32.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_base <= '0;
    end else if (i_calc) begin
      r_base <= VrfBaseAddr + (32'(i_idx) << VlenbShift);
    end
  end

  // Word offset: cleared on load, post-incremented on advance, wraps to 0 after the last word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_off <= '0;
    end else if (i_load) begin
      r_off <= '0;
    end else if (i_adv) begin
      r_off <= w_at_last ? '0 : r_off + OffOne;
    end
  end

  assign o_addr = r_base + (32'(r_off) << WordShift);

endmodule

// File: rtl/vcve2_vrf_agu.sv
// VRF address generation unit: latches operand indices, computes bases, hands out word addresses.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   AGU_IDLE  | no valid operands since reset; gets are rejected
//   AGU_CALC  | indices latched, bases being registered, range checked
//   AGU_READY | bases valid; get_* strobes emit and advance pointers
module vcve2_vrf_agu
  import vcve2_vrf_agu_pkg::*;
#(
  parameter int unsigned VLEN        = VLENB * 8,
  parameter int unsigned PIPE_WIDTH  = WORD_BYTES * 8,
  parameter int unsigned AddrWidth   = 5,
  parameter logic [31:0] VrfBaseAddr = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  vcve2_vrf_agu_if.slave  bus
);

  localparam int unsigned WordsPerReg = VLEN / PIPE_WIDTH;
  localparam int unsigned MaxWords    = WordsPerReg * 8;
  localparam int unsigned OffWidth    = (MaxWords > 1) ? $clog2(MaxWords) : 1;
  localparam int unsigned NwWidth     = OffWidth + 1;
  localparam int unsigned VlenbShift  = $clog2(VLEN / 8);
  localparam int unsigned WordShift   = $clog2(PIPE_WIDTH / 8);
  localparam int unsigned NumRegs     = 1 << AddrWidth;

  agu_state_t                            r_state;
  agu_state_t                            w_state_next;
  vlmul_e                                r_lmul;
  logic [NUM_MEM_OPS-1:0][AddrWidth-1:0] r_idx;

  logic [NwWidth-1:0]                    w_nw;
  int unsigned                           w_span;
  logic                                  w_range_err;
  logic [NUM_MEM_OPS-1:0]                w_get;
  logic [NUM_MEM_OPS-1:0]                w_win;
  logic [NUM_MEM_OPS-1:0]                w_adv;
  logic [NUM_MEM_OPS-1:0][31:0]          w_addr;
  logic                                  w_multi;
  logic                                  w_calc;
  logic                                  w_ready;
  logic                                  w_err;
  logic [31:0]                           w_addr_out;
  logic                                  w_unused_sel;

  // Only bit 3 of the operation select affects addressing.
  assign w_unused_sel = ^bus.sel_operation_i[2:0];

  assign w_nw   = NwWidth'(lmul_words(r_lmul, WordsPerReg));
  assign w_span = lmul_span(r_lmul);
  assign w_get  = {bus.get_rd_i, bus.get_rs2_i, bus.get_rs1_i};

  // Any operand group running past the last architectural register is a range error.
  always_comb begin
    w_range_err = 1'b0;
    for (int unsigned i = 0; i < NUM_MEM_OPS; i++) begin
      if (32'(r_idx[i]) + w_span > NumRegs) w_range_err = 1'b1;
    end
  end

  // Operand indices and LMUL are captured on every load, regardless of state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx  <= '0;
      r_lmul <= LMUL_1;
    end else if (bus.load_i) begin
      r_idx[OP_RS1] <= bus.vs1_i;
      r_idx[OP_RS2] <= bus.vs2_i;
      r_idx[OP_RD]  <= bus.vd_i;
      r_lmul        <= bus.lmul_i;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= AGU_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, get arbitration (rs1 > rs2 > rd), address mux and error pulse.
  always_comb begin
    w_state_next = r_state;
    w_calc       = 1'b0;
    w_ready      = 1'b0;
    w_err        = 1'b0;
    w_win        = '0;
    w_adv        = '0;
    w_addr_out   = '0;
    w_multi      = (w_get[OP_RS1] & w_get[OP_RS2]) | (w_get[OP_RS1] & w_get[OP_RD]) |
                   (w_get[OP_RS2] & w_get[OP_RD]);

    case (r_state)
      AGU_IDLE: begin
        w_state_next = AGU_IDLE;
      end
      AGU_CALC: begin
        w_calc       = 1'b1;
        w_state_next = AGU_READY;
        if (w_range_err || (r_lmul == LMUL_RSVD)) w_err = 1'b1;
      end
      AGU_READY: begin
        w_ready = 1'b1;
      end
      default: begin
        w_state_next = AGU_IDLE;
      end
    endcase

    // A load restarts the unit and swallows any get presented alongside it.
    if (bus.load_i) begin
      w_state_next = AGU_CALC;
    end else if (|w_get) begin
      if (!w_ready) begin
        w_err = 1'b1;
      end else begin
        if (w_get[OP_RS1])      w_win[OP_RS1] = 1'b1;
        else if (w_get[OP_RS2]) w_win[OP_RS2] = 1'b1;
        else                    w_win[OP_RD]  = 1'b1;
        if (w_multi) w_err = 1'b1;
      end
    end

    // A read of vd ahead of its write-back keeps the same address for the write.
    w_adv[OP_RS1] = w_win[OP_RS1];
    w_adv[OP_RS2] = w_win[OP_RS2];
    w_adv[OP_RD]  = w_win[OP_RD] & (bus.data_we_i | ~bus.sel_operation_i[3]);

    if (w_win[OP_RS1])      w_addr_out = w_addr[OP_RS1];
    else if (w_win[OP_RS2]) w_addr_out = w_addr[OP_RS2];
    else if (w_win[OP_RD])  w_addr_out = w_addr[OP_RD];
  end

  for (genvar g = 0; g < NUM_MEM_OPS; g++) begin : g_ptr
    vcve2_vrf_agu_ptr #(
      .AddrWidth   (AddrWidth),
      .OffWidth    (OffWidth),
      .VlenbShift  (VlenbShift),
      .WordShift   (WordShift),
      .VrfBaseAddr (VrfBaseAddr)
    ) u_ptr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .i_load (bus.load_i),
      .i_calc (w_calc),
      .i_adv  (w_adv[g]),
      .i_idx  (r_idx[g]),
      .i_nw   (w_nw),
      .o_addr (w_addr[g])
    );
  end

  assign bus.ready_o     = w_ready;
  assign bus.data_addr_o = w_addr_out;
  assign bus.err_o       = w_err;

endmodule

// File: tb/tb_vcve2_vrf_agu.sv
// Scoreboard bench for the VRF AGU: stimulus queues expected responses, a monitor checks them.
module tb_vcve2_vrf_agu;
  import vcve2_vrf_agu_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  vcve2_vrf_agu_if #(.AddrWidth(5)) bus ();

  vcve2_vrf_agu #(
    .VLEN        (128),
    .PIPE_WIDTH  (32),
    .AddrWidth   (5),
    .VrfBaseAddr (32'h0000_0000)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  typedef struct {
    string       nm;
    logic [31:0] addr;
    logic        err;
    logic        rdy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  logic sample = 1'b0;

  // Monitor: on each sampled cycle pop one expectation and compare all three outputs.
  always @(negedge clk_i) begin
    if (sample) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_underflow got=empty want=entry");
      end else begin
        mon_e = exp_q.pop_front();
        total += 3;
        if (bus.data_addr_o !== mon_e.addr) begin
          bad++;
          $display("FAIL %s addr got=%h want=%h", mon_e.nm, bus.data_addr_o, mon_e.addr);
        end
        if (bus.err_o !== mon_e.err) begin
          bad++;
          $display("FAIL %s err got=%b want=%b", mon_e.nm, bus.err_o, mon_e.err);
        end
        if (bus.ready_o !== mon_e.rdy) begin
          bad++;
          $display("FAIL %s ready got=%b want=%b", mon_e.nm, bus.ready_o, mon_e.rdy);
        end
      end
    end
  end

  // One clock of stimulus; inputs are applied 1 time unit after the rising edge.
  task automatic step(input logic ld, input logic g1, input logic g2, input logic gd,
                      input logic we, input logic s3, input logic chk,
                      input logic [31:0] ea, input logic ee, input logic er, input string nm);
    exp_t e;
    bus.load_i          = ld;
    bus.get_rs1_i       = g1;
    bus.get_rs2_i       = g2;
    bus.get_rd_i        = gd;
    bus.data_we_i       = we;
    bus.sel_operation_i = {s3, 3'b000};
    sample              = chk;
    if (chk) begin
      e.nm = nm; e.addr = ea; e.err = ee; e.rdy = er;
      exp_q.push_back(e);
    end
    @(posedge clk_i);
    #1;
    bus.load_i = 0; bus.get_rs1_i = 0; bus.get_rs2_i = 0; bus.get_rd_i = 0;
    bus.data_we_i = 0; bus.sel_operation_i = '0;
    sample = 1'b0;
  endtask

  task automatic get1(input logic [31:0] a, input string nm);
    step(0, 1, 0, 0, 0, 0, 1, a, 0, 1, nm);
  endtask

  task automatic get2(input logic [31:0] a, input string nm);
    step(0, 0, 1, 0, 0, 0, 1, a, 0, 1, nm);
  endtask

  task automatic getd(input logic we, input logic s3, input logic [31:0] a, input string nm);
    step(0, 0, 0, 1, we, s3, 1, a, 0, 1, nm);
  endtask

  // Load cycle plus the CALC cycle (ready low, range/reserved error as given).
  task automatic load(input logic [4:0] v1, input logic [4:0] v2, input logic [4:0] vd,
                      input vlmul_e lm, input logic rdy_now, input logic calc_err,
                      input string nm);
    bus.vs1_i = v1; bus.vs2_i = v2; bus.vd_i = vd; bus.lmul_i = lm;
    step(1, 0, 0, 0, 0, 0, 1, 32'h0, 0, rdy_now, {nm, "_load"});
    step(0, 0, 0, 0, 0, 0, 1, 32'h0, calc_err, 0, {nm, "_calc"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    bus.load_i = 0; bus.vs1_i = '0; bus.vs2_i = '0; bus.vd_i = '0; bus.lmul_i = LMUL_1;
    bus.get_rs1_i = 0; bus.get_rs2_i = 0; bus.get_rd_i = 0; bus.data_we_i = 0;
    bus.sel_operation_i = '0;
    @(posedge clk_i);
    #1;
    step(0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, "reset");
    rst_ni = 1'b1;

    // get before any load
    step(0, 1, 0, 0, 0, 0, 1, 32'h0, 1, 0, "idle_get");

    // basic m1 rounds
    load(2, 3, 4, LMUL_1, 0, 0, "m1");
    get1(32'h20, "m1_rs1_a");
    get2(32'h30, "m1_rs2_a");
    getd(1, 0, 32'h40, "m1_rd_a");
    get1(32'h24, "m1_rs1_b");
    get2(32'h34, "m1_rs2_b");
    getd(1, 0, 32'h44, "m1_rd_b");

    // read-modify-write on vd, then wrap of the rd pointer
    load(2, 3, 4, LMUL_1, 1, 0, "rmw");
    getd(0, 1, 32'h40, "rmw_read");
    getd(1, 1, 32'h40, "rmw_write");
    getd(1, 1, 32'h44, "rmw_next");
    getd(0, 0, 32'h48, "rd_nowe_adv");
    getd(1, 0, 32'h4C, "rd_last");
    getd(1, 0, 32'h40, "rd_wrap");

    // m2 group: 8 words then wrap
    load(8, 0, 0, LMUL_2, 1, 0, "m2");
    for (int i = 0; i < 8; i++) get1(32'h80 + 32'(i) * 4, "m2_rs1");
    get1(32'h80, "m2_wrap");

    // mf2: two words per group
    load(8, 0, 0, LMUL_F2, 1, 0, "mf2");
    get1(32'h80, "mf2_0");
    get1(32'h84, "mf2_1");
    get1(32'h80, "mf2_wrap");

    // mf8: clamps to one word
    load(5, 0, 0, LMUL_F8, 1, 0, "mf8");
    get1(32'h50, "mf8_0");
    get1(32'h50, "mf8_wrap");

    // simultaneous gets
    load(2, 3, 4, LMUL_1, 1, 0, "sim");
    step(0, 1, 0, 1, 1, 0, 1, 32'h20, 1, 1, "sim_rs1_rd");
    getd(1, 0, 32'h40, "sim_rd_untouched");
    get1(32'h24, "sim_rs1_adv");
    step(0, 0, 1, 1, 1, 0, 1, 32'h30, 1, 1, "sim_rs2_rd");
    getd(1, 0, 32'h44, "sim_rd_untouched2");
    step(0, 1, 1, 1, 1, 0, 1, 32'h28, 1, 1, "sim_all");
    get2(32'h34, "sim_rs2_adv");

    // get during CALC is rejected and does not advance
    bus.vs1_i = 2; bus.vs2_i = 3; bus.vd_i = 4; bus.lmul_i = LMUL_1;
    step(1, 0, 0, 0, 0, 0, 1, 32'h0, 0, 1, "calcget_load");
    step(0, 1, 0, 0, 0, 0, 1, 32'h0, 1, 0, "calcget_get");
    get1(32'h20, "calcget_after");
    get1(32'h24, "midop_1");
    get1(32'h28, "midop_2");

    // restart mid-operation clears offsets
    load(2, 3, 4, LMUL_1, 1, 0, "restart");
    get1(32'h20, "restart_rs1");
    get2(32'h30, "restart_rs2");

    // load and get in the same cycle: load wins
    step(1, 1, 0, 0, 0, 0, 1, 32'h0, 0, 1, "loadget_load");
    step(0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, "loadget_calc");
    get1(32'h20, "loadget_after");

    // range checks
    load(0, 0, 30, LMUL_4, 1, 1, "vd30m4");
    getd(1, 0, 32'h1E0, "vd30m4_addr");
    load(0, 0, 28, LMUL_4, 1, 0, "vd28m4");
    getd(1, 0, 32'h1C0, "vd28m4_addr");
    load(24, 0, 0, LMUL_8, 1, 0, "vs24m8");
    get1(32'h180, "vs24m8_addr");
    load(0, 25, 0, LMUL_8, 1, 1, "vs25m8");
    get2(32'h190, "vs25m8_addr");

    // reserved lmul behaves as m1 with an error
    load(1, 1, 1, LMUL_RSVD, 1, 1, "rsvd");
    for (int i = 0; i < 4; i++) get1(32'h10 + 32'(i) * 4, "rsvd_rs1");
    get1(32'h10, "rsvd_wrap");

    // asynchronous reset while READY
    rst_ni = 1'b0;
    step(0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, "rst_ready");
    rst_ni = 1'b1;
    step(0, 1, 0, 0, 0, 0, 1, 32'h0, 1, 0, "rst_get_noload");
    load(2, 3, 4, LMUL_1, 0, 0, "resume");
    get1(32'h20, "resume_rs1");

    @(posedge clk_i);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
